eth_rx_frame_ctrl: RTL and testbench

// Sequences the byte stream from the RGMII RX PHY interface (rx_data/rx_dv/rx_er, clk_125 domain) into frames.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_crc32_d8.sv | 19 +
 rtl/eth_rx_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet RX constants, FSM state encodings and the CRC-32 parameters
// used by the frame controller and its CRC helper.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef logic [2:0] rx_state_t;

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_PREAMBLE  = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_DROP      = 3'd4;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32, one byte per call;
// the CRC register itself lives in the caller.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // LSB-first bit-serial update unrolled over the eight data bits
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// RGMII RX byte-stream framer: strips preamble/SFD, filters on destination MAC,
// checks length and CRC-32, withholds the FCS and counts good/bad/filtered frames.
module eth_rx_frame_ctrl
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
    parameter int          MIN_PREAMBLE = 1,
    parameter int          MIN_FRAME    = 64,
    parameter int          MAX_FRAME    = 1518
) (
    input  logic        clk_125,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic        promisc,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_bad,
    output logic [31:0] cnt_filt
);

    localparam logic [3:0]  MIN_PRE = 4'(MIN_PREAMBLE);
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);

    rx_state_t       state;
    logic [3:0]      pre_cnt;
    logic [10:0]     len;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic            err;
    logic [4:0][7:0] dline;
    logic [47:0]     dst;
    logic            mac_pass;
    logic            end_bad;

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    // Bytes 0..4 sit in the delay line while byte 5 is on the wire
    assign dst      = {dline[4], dline[3], dline[2], dline[1], dline[0], rx_data};
    assign mac_pass = promisc || (dst == MAC_ADDR) || (dst == MAC_BCAST);
    assign end_bad  = (crc != CRC32_RESIDUE) || err || (len < MIN_LEN);

    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT_IDLE;
            pre_cnt  <= '0;
            len      <= '0;
            crc      <= CRC32_INIT;
            err      <= 1'b0;
            dline    <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            cnt_good <= '0;
            cnt_bad  <= '0;
            cnt_filt <= '0;
        end else begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            case (state)
                ST_WAIT_IDLE: begin
                    if (!rx_dv) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (rx_dv) begin
                        if (rx_data == ETH_PREAMBLE) begin
                            state   <= ST_PREAMBLE;
                            pre_cnt <= 4'd1;
                        end else begin
                            state    <= ST_DROP;
                            cnt_filt <= cnt_filt + 32'd1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_dv) begin
                        state    <= ST_IDLE;
                        cnt_filt <= cnt_filt + 32'd1;
                    end else if (rx_data == ETH_PREAMBLE) begin
                        if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
                    end else if (rx_data == ETH_SFD && pre_cnt >= MIN_PRE) begin
                        state <= ST_DATA;
                        crc   <= CRC32_INIT;
                        len   <= '0;
                        err   <= 1'b0;
                    end else begin
                        state    <= ST_DROP;
                        cnt_filt <= cnt_filt + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                        if (len < 11'd6) begin
                            cnt_bad <= cnt_bad + 32'd1;
                        end else begin
                            m_tdata  <= dline[4];
                            m_tvalid <= 1'b1;
                            m_tlast  <= 1'b1;
                            m_tuser  <= end_bad;
                            if (end_bad) cnt_bad  <= cnt_bad + 32'd1;
                            else         cnt_good <= cnt_good + 32'd1;
                        end
                    end else if (len == 11'd5 && !mac_pass) begin
                        state    <= ST_DROP;
                        cnt_filt <= cnt_filt + 32'd1;
                    end else if (len == MAX_LEN) begin
                        // Giant: close the frame on the held byte and discard the rest
                        m_tdata  <= dline[4];
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b1;
                        m_tuser  <= 1'b1;
                        cnt_bad  <= cnt_bad + 32'd1;
                        state    <= ST_DROP;
                    end else begin
                        if (len >= 11'd5) begin
                            m_tdata  <= dline[4];
                            m_tvalid <= 1'b1;
                        end
                        crc   <= crc_next;
                        err   <= err | rx_er;
                        dline <= {dline[3:0], rx_data};
                        if (len != 11'h7FF) len <= len + 11'd1;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) state <= ST_IDLE;
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: a table of frames plus hand-written
// sequences for giant, back-to-back, preamble error and mid-frame reset.
module tb_eth_rx_frame_ctrl;

    logic        clk_125 = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dv   = 1'b0;
    logic        rx_er   = 1'b0;
    logic        promisc = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] cnt_good;
    logic [31:0] cnt_bad;
    logic [31:0] cnt_filt;

    eth_rx_frame_ctrl dut (
        .clk_125  (clk_125),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_dv    (rx_dv),
        .rx_er    (rx_er),
        .promisc  (promisc),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .cnt_good (cnt_good),
        .cnt_bad  (cnt_bad),
        .cnt_filt (cnt_filt)
    );

    always #4 clk_125 = ~clk_125;

    int cyc = 0;
    always @(posedge clk_125) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] dst;
        int          len;
        bit          prom;
        bit          bad_fcs;
        int          er_idx;
        int          exp_beats;
        bit          exp_tuser;
        int          d_good;
        int          d_bad;
        int          d_filt;
    } vec_t;

    vec_t        vecs [11];
    logic [7:0]  frm [0:1599];
    int          samp_cyc [0:1600];

    logic [7:0]  beat_data [$];
    int          beat_cyc [$];
    int          last_cnt = 0;
    int          last_idx = 0;
    logic        last_tuser = 1'b0;

    int total_checks = 0;
    int passed_checks = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int exp_filt = 0;

    // Beat monitor, sampled on the falling edge away from the DUT's active edge
    always @(negedge clk_125) begin
        if (m_tvalid) begin
            beat_data.push_back(m_tdata);
            beat_cyc.push_back(cyc);
            if (m_tlast) begin
                last_cnt   = last_cnt + 1;
                last_idx   = beat_data.size() - 1;
                last_tuser = m_tuser;
            end
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total_checks = total_checks + 1;
        if (act == exp) passed_checks = passed_checks + 1;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] crc_bytes(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input int len, input bit bad_fcs);
        logic [31:0] fcs;
        logic [47:0] src;
        src = 48'h02_00_00_00_00_99;
        for (int i = 0; i < len; i++) frm[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 6; i++) frm[i] = dst[47 - 8 * i -: 8];
        if (len > 11) for (int i = 0; i < 6; i++) frm[6 + i] = src[47 - 8 * i -: 8];
        if (len >= 10) begin
            fcs = ~crc_bytes(len - 4);
            frm[len - 4] = fcs[7:0];
            frm[len - 3] = fcs[15:8];
            frm[len - 2] = fcs[23:16];
            frm[len - 1] = fcs[31:24];
            if (bad_fcs) frm[len - 1] = frm[len - 1] ^ 8'h40;
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input logic er);
        @(negedge clk_125);
        rx_data = b;
        rx_dv   = 1'b1;
        rx_er   = er;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk_125);
            rx_dv   = 1'b0;
            rx_er   = 1'b0;
            rx_data = 8'h00;
        end
    endtask

    task automatic drive_frame(input int n, input int er_idx);
        repeat (7) put_byte(8'h55, 1'b0);
        put_byte(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) begin
            put_byte(frm[i], i == er_idx);
            samp_cyc[i] = cyc + 1;
        end
        idle_cycles(1);
        samp_cyc[n] = cyc + 1;
    endtask

    task automatic verify_capture(input string name, input int base, input int lbase,
                                  input int exp_beats, input int period, input int exp_last,
                                  input bit exp_tuser, input bit chk_time);
        int n;
        int d_err;
        int t_err;
        n = beat_data.size() - base;
        d_err = 0;
        t_err = 0;
        checkOutput({name, " beats"}, n, exp_beats);
        for (int k = 0; k < n && k < exp_beats; k++) begin
            if (beat_data[base + k] != frm[k % period]) d_err++;
            if (chk_time && beat_cyc[base + k] != samp_cyc[k + 5]) t_err++;
        end
        checkOutput({name, " data errors"}, d_err, 0);
        if (chk_time) checkOutput({name, " timing errors"}, t_err, 0);
        checkOutput({name, " tlast count"}, last_cnt - lbase, exp_last);
        if (exp_last > 0) begin
            checkOutput({name, " tlast index"}, last_idx - base, exp_beats - 1);
            checkOutput({name, " tuser"}, longint'(last_tuser), longint'(exp_tuser));
        end
    endtask

    task automatic check_counters(input string name);
        checkOutput({name, " cnt_good"}, longint'(cnt_good), exp_good);
        checkOutput({name, " cnt_bad"},  longint'(cnt_bad),  exp_bad);
        checkOutput({name, " cnt_filt"}, longint'(cnt_filt), exp_filt);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int base;
        int lbase;
        build_frame(v.dst, v.len, v.bad_fcs);
        promisc = v.prom;
        base  = beat_data.size();
        lbase = last_cnt;
        drive_frame(v.len, v.er_idx);
        idle_cycles(4);
        exp_good = exp_good + v.d_good;
        exp_bad  = exp_bad + v.d_bad;
        exp_filt = exp_filt + v.d_filt;
        verify_capture(name, base, lbase, v.exp_beats, 1600,
                       (v.exp_beats > 0) ? 1 : 0, v.exp_tuser, 1'b1);
        check_counters(name);
    endtask

    initial begin
        int base;
        int lbase;

        vecs[0]  = '{48'h020000000001,   64, 1'b0, 1'b0, -1,   60, 1'b0, 1, 0, 0};
        vecs[1]  = '{48'h020000000001,   64, 1'b0, 1'b1, -1,   60, 1'b1, 0, 1, 0};
        vecs[2]  = '{48'h020000000002,   64, 1'b0, 1'b0, -1,    0, 1'b0, 0, 0, 1};
        vecs[3]  = '{48'h020000000002,   64, 1'b1, 1'b0, -1,   60, 1'b0, 1, 0, 0};
        vecs[4]  = '{48'hFFFFFFFFFFFF,   64, 1'b0, 1'b0, -1,   60, 1'b0, 1, 0, 0};
        vecs[5]  = '{48'h020000000001,   40, 1'b0, 1'b0, -1,   36, 1'b1, 0, 1, 0};
        vecs[6]  = '{48'h020000000001,   64, 1'b0, 1'b0, 20,   60, 1'b1, 0, 1, 0};
        vecs[7]  = '{48'h020000000001, 1518, 1'b0, 1'b0, -1, 1514, 1'b0, 1, 0, 0};
        vecs[8]  = '{48'h020000000001,    5, 1'b0, 1'b0, -1,    0, 1'b0, 0, 1, 0};
        vecs[9]  = '{48'h020000000001,   65, 1'b0, 1'b0, -1,   61, 1'b0, 1, 0, 0};
        vecs[10] = '{48'h020000000001,   63, 1'b0, 1'b0, -1,   59, 1'b1, 0, 1, 0};

        repeat (3) @(negedge clk_125);
        checkOutput("reset m_tvalid", longint'(m_tvalid), 0);
        checkOutput("reset m_tlast",  longint'(m_tlast),  0);
        checkOutput("reset m_tuser",  longint'(m_tuser),  0);
        checkOutput("reset m_tdata",  longint'(m_tdata),  0);
        check_counters("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Giant: 1600 bytes to our MAC, closed after 1514 beats
        for (int i = 0; i < 1600; i++) frm[i] = 8'(i * 13 + 1);
        build_frame(48'h020000000001, 6, 1'b0);
        for (int i = 6; i < 1600; i++) frm[i] = 8'(i * 13 + 1);
        promisc = 1'b0;
        base  = beat_data.size();
        lbase = last_cnt;
        drive_frame(1600, -1);
        idle_cycles(4);
        exp_bad = exp_bad + 1;
        verify_capture("giant", base, lbase, 1514, 1600, 1, 1'b1, 1'b1);
        check_counters("giant");

        // Back-to-back good frames with a single idle cycle between them
        build_frame(48'h020000000001, 64, 1'b0);
        base  = beat_data.size();
        lbase = last_cnt;
        drive_frame(64, -1);
        drive_frame(64, -1);
        idle_cycles(4);
        exp_good = exp_good + 2;
        verify_capture("b2b", base, lbase, 120, 60, 2, 1'b0, 1'b0);
        check_counters("b2b");

        // Preamble error 55,55,A5 followed by data that must be discarded
        base  = beat_data.size();
        lbase = last_cnt;
        put_byte(8'h55, 1'b0);
        put_byte(8'h55, 1'b0);
        put_byte(8'hA5, 1'b0);
        for (int i = 0; i < 20; i++) put_byte(frm[i], 1'b0);
        idle_cycles(4);
        exp_filt = exp_filt + 1;
        verify_capture("preerr", base, lbase, 0, 1600, 0, 1'b0, 1'b0);
        check_counters("preerr");

        // Reset in the middle of DATA, released while rx_dv is still high
        repeat (7) put_byte(8'h55, 1'b0);
        put_byte(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) put_byte(frm[i], 1'b0);
        @(negedge clk_125);
        rx_data = frm[30];
        rst_n   = 1'b0;
        #1;
        checkOutput("rstmid m_tvalid", longint'(m_tvalid), 0);
        exp_good = 0;
        exp_bad  = 0;
        exp_filt = 0;
        check_counters("rstmid clear");
        base  = beat_data.size();
        lbase = last_cnt;
        for (int i = 31; i < 64; i++) begin
            put_byte(frm[i], 1'b0);
            if (i == 33) rst_n = 1'b1;
        end
        idle_cycles(4);
        verify_capture("rstmid", base, lbase, 0, 1600, 0, 1'b0, 1'b0);
        check_counters("rstmid");
        applyStimulus(vecs[0], "postrst");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
